// File: rtl/cpu_pkg.sv
// cpu_pkg: control-word bit map, opcodes, flag indices and FSM states shared by CU and datapath
package cpu_pkg;
  localparam int PC2MAR     = 0;
  localparam int MBR2MAR    = 1;
  localparam int PC2MBR     = 2;
  localparam int MBR2PC     = 3;
  localparam int MBR2IR     = 4;
  localparam int MBR2BR     = 5;
  localparam int MBR2ACC    = 6;
  localparam int ACC2MBR    = 7;
  localparam int MR2MBR     = 8;
  localparam int ALU2MBR    = 9;
  localparam int MEMORY2MBR = 10;
  localparam int MBR2MEMORY = 11;
  localparam int MAR2MEMORY = 12;
  localparam int IR2CU      = 13;
  localparam int PC_PLUS1   = 14;
  localparam int ACC2ALU    = 15;
  localparam int BR2ALU     = 16;
  localparam int CAR_INC    = 17;
  localparam int CAR_LOAD   = 18;
  localparam int CAR_RESET  = 19;
  localparam int ACC_CLEAR  = 20;
  localparam int RSVD21     = 21;
  localparam int ALU_ADD    = 22;
  localparam int ALU_SUB    = 23;
  localparam int ALU_AND    = 24;
  localparam int ALU_OR     = 25;
  localparam int ALU_NOT    = 26;
  localparam int ALU_LSL    = 27;
  localparam int ALU_LSR    = 28;
  localparam int ALU_ASL    = 29;
  localparam int ALU_ASR    = 30;
  localparam int ALU_MPY    = 31;
  localparam int ALU_LO     = ALU_ADD;
  localparam int ALU_N      = 10;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_MPY   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'hFF;
  localparam int F_NEG   = 0;
  localparam int F_ZERO  = 1;
  localparam int F_CARRY = 2;
  localparam int F_OVF   = 3;
  localparam int F_ERR   = 4;
  typedef enum logic {S_IDLE, S_REQ} dp_state_e;
endpackage

// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: external memory request/ack handshake
interface cpu_datapath_if #(parameter int DW = 16, parameter int AW = 8);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU driven by a one-hot op (index = control bit - ALU_LO)
module dp_alu
  import cpu_pkg::*;
#(parameter int DW = 16) (
  input  logic [ALU_N-1:0] op_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [DW-1:0]    result_o,
  output logic [DW-1:0]    hi_o,
  output logic             c_o,
  output logic             v_o
);
  logic [DW:0]     sum, dif;
  logic [2*DW-1:0] prod;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign dif  = {1'b0, a_i} - {1'b0, b_i};
  assign prod = {{DW{a_i[DW-1]}}, a_i} * {{DW{b_i[DW-1]}}, b_i};
  // select the single active operation; carry is the adder carry, the borrow, or the bit shifted out
  always_comb begin
    result_o = '0;
    hi_o     = '0;
    c_o      = 1'b0;
    v_o      = 1'b0;
    if (op_i[ALU_ADD-ALU_LO]) begin
      {c_o, result_o} = sum;
      v_o = (a_i[DW-1] == b_i[DW-1]) && (sum[DW-1] != a_i[DW-1]);
    end else if (op_i[ALU_SUB-ALU_LO]) begin
      {c_o, result_o} = dif;
      v_o = (a_i[DW-1] != b_i[DW-1]) && (dif[DW-1] != a_i[DW-1]);
    end else if (op_i[ALU_AND-ALU_LO]) result_o = a_i & b_i;
    else if (op_i[ALU_OR-ALU_LO])      result_o = a_i | b_i;
    else if (op_i[ALU_NOT-ALU_LO])     result_o = ~b_i;
    else if (op_i[ALU_LSL-ALU_LO] || op_i[ALU_ASL-ALU_LO]) begin
      result_o = {a_i[DW-2:0], 1'b0};
      c_o      = a_i[DW-1];
      v_o      = op_i[ALU_ASL-ALU_LO] && (a_i[DW-1] != a_i[DW-2]);
    end else if (op_i[ALU_LSR-ALU_LO] || op_i[ALU_ASR-ALU_LO]) begin
      result_o = {op_i[ALU_ASR-ALU_LO] & a_i[DW-1], a_i[DW-1:1]};
      c_o      = a_i[0];
    end else if (op_i[ALU_MPY-ALU_LO]) {hi_o, result_o} = prod;
  end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: register-transfer datapath with memory handshake and skid buffer; DP_MEM_TIMEOUT_EN adds an ack watchdog
module cpu_datapath
  import cpu_pkg::*;
#(parameter int DW = 16, parameter int AW = 8, parameter int TIMEOUT = 64) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  control_signal,
  output logic [7:0]   data_from_ir,
  output logic [7:0]   flags,
  output logic         stall,
  cpu_datapath_if.master mem
);
  dp_state_e       state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, mar_q, mar_d, addr_q, addr_d;
  logic [DW-1:0]   mbr_q, mbr_d, ir_q, ir_d, br_q, br_d, acc_q, acc_d, mr_q, mr_d, aluq_q, aluq_d, wdata_q, wdata_d;
  logic [31:0]     skid_q, skid_d, cw;
  logic            skid_v_q, skid_v_d, we_q, we_d, err_q, err_d;
  logic [3:0]      nzcv_q, nzcv_d;
  logic [7:0]      dfi_q, dfi_d;
  logic [ALU_N-1:0] alu_bits, alu_op;
  logic [DW-1:0]   alu_a, alu_res, alu_hi;
  logic            alu_c, alu_v, alu_en, alu_multi, is_mpy;
  logic            req, arrive, drop, rd, wr, start, ack_ok, rd_done, tmo;
  assign req    = state_q == S_REQ;
  assign arrive = |control_signal;
  assign drop   = req && arrive && skid_v_q;
  assign cw     = req ? '0 : skid_v_q ? skid_q : control_signal;
  assign rd     = cw[MEMORY2MBR];
  assign wr     = cw[MBR2MEMORY];
  assign start  = rd || wr;
  assign ack_ok = req && mem.mem_ack;
  assign rd_done = ack_ok && !we_q;
  assign alu_bits  = cw[ALU_MPY:ALU_LO];
  assign alu_op    = alu_bits & (~alu_bits + 1'b1);
  assign alu_multi = |(alu_bits & (alu_bits - 1'b1));
  assign alu_en    = |alu_bits;
  assign is_mpy    = alu_op[ALU_MPY-ALU_LO];
  assign alu_a     = cw[ACC_CLEAR] ? '0 : acc_q;
  dp_alu #(.DW(DW)) u_alu (.op_i(alu_op), .a_i(alu_a), .b_i(br_q), .result_o(alu_res), .hi_o(alu_hi), .c_o(alu_c), .v_o(alu_v));
`ifdef DP_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = req && !mem.mem_ack && cnt_q == CW'(TIMEOUT - 1);
  // count cycles spent waiting for ack; cleared outside REQ
  always_ff @(posedge clk)
    cnt_q <= (rst || !req || tmo) ? '0 : cnt_q + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // next-state: FSM, skid buffer, register transfers and flags
  always_comb begin
    state_d  = start ? S_REQ : (ack_ok || tmo) ? S_IDLE : state_q;
    skid_v_d = req ? (skid_v_q || arrive) : (skid_v_q && arrive);
    skid_d   = (req ? !skid_v_q : skid_v_q) ? control_signal : skid_q;
    we_d     = start ? !rd : we_q;
    addr_d   = start ? mar_q : addr_q;
    wdata_d  = start ? mbr_q : wdata_q;
    err_d    = err_q || drop || (rd && wr) || alu_multi || tmo;
    pc_d     = cw[MBR2PC] ? mbr_q[AW-1:0] : cw[PC_PLUS1] ? pc_q + 1'b1 : pc_q;
    mar_d    = cw[PC2MAR] ? pc_q : cw[MBR2MAR] ? mbr_q[AW-1:0] : mar_q;
    mbr_d    = rd_done ? mem.mem_rdata : cw[ALU2MBR] ? aluq_q : cw[MR2MBR] ? mr_q :
               cw[ACC2MBR] ? acc_q : cw[PC2MBR] ? {{(DW-AW){1'b0}}, pc_q} : mbr_q;
    ir_d     = cw[MBR2IR] ? mbr_q : ir_q;
    br_d     = cw[MBR2BR] ? mbr_q : br_q;
    acc_d    = alu_en ? alu_res : cw[ACC_CLEAR] ? '0 : cw[MBR2ACC] ? mbr_q : acc_q;
    mr_d     = is_mpy ? alu_hi : mr_q;
    aluq_d   = alu_en ? alu_res : aluq_q;
    nzcv_d   = alu_en ? {alu_v, alu_c, is_mpy ? ~|{alu_hi, alu_res} : ~|alu_res, is_mpy ? alu_hi[DW-1] : alu_res[DW-1]} : nzcv_q;
    dfi_d    = cw[IR2CU] ? ir_q[DW-1:DW-8] : dfi_q;
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      {skid_q, skid_v_q, we_q, err_q, addr_q, wdata_q} <= '0;
      {pc_q, mar_q, mbr_q, ir_q, br_q, acc_q, mr_q, aluq_q, nzcv_q, dfi_q} <= '0;
    end else begin
      state_q <= state_d;
      {skid_q, skid_v_q, we_q, err_q, addr_q, wdata_q} <= {skid_d, skid_v_d, we_d, err_d, addr_d, wdata_d};
      {pc_q, mar_q, mbr_q, ir_q, br_q, acc_q, mr_q, aluq_q, nzcv_q, dfi_q} <= {pc_d, mar_d, mbr_d, ir_d, br_d, acc_d, mr_d, aluq_d, nzcv_d, dfi_d};
    end
  end
  assign stall         = req;
  assign mem.mem_req   = req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign data_from_ir  = dfi_q;
  assign flags         = {3'b000, err_q, nzcv_q};
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed tests of transfers, ALU, memory handshake, skid buffer and timeout
module tb_cpu_datapath;
  import cpu_pkg::*;
`ifdef DP_MEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif
  logic clk = 0, rst = 0;
  logic [31:0] cs = '0;
  logic [7:0] dfi, flags;
  logic stall;
  int tests = 0, fails = 0;
  cpu_datapath_if #(.DW(16), .AW(8)) mem_if ();
  cpu_datapath #(.DW(16), .AW(8), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .control_signal(cs),
    .data_from_ir(dfi), .flags(flags), .stall(stall), .mem(mem_if));
  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  task automatic cyc(input logic [31:0] w);
    cs = w;
    @(posedge clk);
    #1 cs = '0;
  endtask

  task automatic ack(input logic [15:0] d);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = d;
    @(posedge clk);
    #1 mem_if.mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_mbr(input logic [15:0] d);
    cyc(b(MEMORY2MBR));
    ack(d);
  endtask

  task automatic test_reset();
    cs = b(PC_PLUS1) | b(ALU_NOT);
    do_reset();
    cs = '0;
    tests++; if (dut.pc_q !== 8'h00) begin fails++; $display("FAIL reset_pc got %h want 00", dut.pc_q); end
    tests++; if (dut.acc_q !== 16'h0000) begin fails++; $display("FAIL reset_acc got %h want 0000", dut.acc_q); end
    tests++; if (flags !== 8'h00) begin fails++; $display("FAIL reset_flags got %h want 00", flags); end
    tests++; if (mem_if.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", mem_if.mem_req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (dfi !== 8'h00) begin fails++; $display("FAIL reset_dfi got %h want 00", dfi); end
  endtask

  task automatic test_fetch();
    cyc(b(PC2MAR));
    cyc(b(MEMORY2MBR));
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fetch_stall0 got %b want 1", stall); end
    tests++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 8'h00)
      begin fails++; $display("FAIL fetch_req got req=%b we=%b addr=%h want 1 0 00", mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr); end
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fetch_stall%0d got %b want 1", i, stall); end
    end
    ack(16'h0305);
    tests++; if (stall !== 1'b0 || mem_if.mem_req !== 1'b0) begin fails++; $display("FAIL fetch_release got stall=%b req=%b want 0 0", stall, mem_if.mem_req); end
    tests++; if (dut.mbr_q !== 16'h0305) begin fails++; $display("FAIL fetch_mbr got %h want 0305", dut.mbr_q); end
    cyc(b(MBR2IR));
    tests++; if (dfi !== 8'h00) begin fails++; $display("FAIL fetch_dfi_early got %h want 00", dfi); end
    cyc(b(IR2CU));
    tests++; if (dfi !== 8'h03) begin fails++; $display("FAIL fetch_dfi got %h want 03", dfi); end
  endtask

  task automatic test_add_overflow();
    load_mbr(16'h7FFF); cyc(b(MBR2ACC));
    load_mbr(16'h0001); cyc(b(MBR2BR));
    cyc(b(ALU_ADD));
    tests++; if (dut.acc_q !== 16'h8000) begin fails++; $display("FAIL add_acc got %h want 8000", dut.acc_q); end
    tests++; if (flags !== 8'h09) begin fails++; $display("FAIL add_flags got %h want 09", flags); end
  endtask

  task automatic test_mpy();
    load_mbr(16'hFFFD); cyc(b(MBR2ACC));
    load_mbr(16'h0100); cyc(b(MBR2BR));
    cyc(b(ALU_MPY));
    tests++; if ({dut.mr_q, dut.acc_q} !== 32'hFFFF_FD00) begin fails++; $display("FAIL mpy_prod got %h want fffffd00", {dut.mr_q, dut.acc_q}); end
    tests++; if (flags !== 8'h01) begin fails++; $display("FAIL mpy_flags got %h want 01", flags); end
    cyc(b(ALU2MBR));
    tests++; if (dut.mbr_q !== 16'hFD00) begin fails++; $display("FAIL mpy_alu2mbr got %h want fd00", dut.mbr_q); end
  endtask

  task automatic test_pc_wrap();
    load_mbr(16'h12FF);
    cyc(b(MBR2PC) | b(PC_PLUS1));
    tests++; if (dut.pc_q !== 8'hFF) begin fails++; $display("FAIL pc_load got %h want ff", dut.pc_q); end
    cyc(b(PC_PLUS1));
    tests++; if (dut.pc_q !== 8'h00) begin fails++; $display("FAIL pc_wrap got %h want 00", dut.pc_q); end
  endtask

  task automatic test_clear_add();
    load_mbr(16'h0005); cyc(b(MBR2ACC));
    load_mbr(16'h0003); cyc(b(MBR2BR));
    cyc(b(ACC_CLEAR) | b(ALU_ADD));
    tests++; if (dut.acc_q !== 16'h0003 || flags !== 8'h00) begin fails++; $display("FAIL clear_add got acc=%h flags=%h want 0003 00", dut.acc_q, flags); end
  endtask

  task automatic test_asr();
    load_mbr(16'h8001); cyc(b(MBR2ACC));
    cyc(b(ALU_ASR));
    tests++; if (dut.acc_q !== 16'hC000 || flags !== 8'h05) begin fails++; $display("FAIL asr got acc=%h flags=%h want c000 05", dut.acc_q, flags); end
  endtask

  task automatic test_write();
    load_mbr(16'hABCD);
    cyc(b(MBR2MEMORY));
    tests++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1 || mem_if.mem_wdata !== 16'hABCD)
      begin fails++; $display("FAIL write_req got req=%b we=%b wdata=%h want 1 1 abcd", mem_if.mem_req, mem_if.mem_we, mem_if.mem_wdata); end
    ack(16'h5555);
    tests++; if (mem_if.mem_req !== 1'b0 || dut.mbr_q !== 16'hABCD) begin fails++; $display("FAIL write_done got req=%b mbr=%h want 0 abcd", mem_if.mem_req, dut.mbr_q); end
  endtask

  task automatic test_skid();
    do_reset();
    load_mbr(16'h0011); cyc(b(MBR2ACC));
    cyc(b(MEMORY2MBR));
    cyc(b(ACC2MBR));
    cyc(b(MBR2BR));
    tests++; if (flags[F_ERR] !== 1'b1) begin fails++; $display("FAIL skid_err got %b want 1", flags[F_ERR]); end
    ack(16'h1234);
    tests++; if (dut.mbr_q !== 16'h1234 || stall !== 1'b0) begin fails++; $display("FAIL skid_ack got mbr=%h stall=%b want 1234 0", dut.mbr_q, stall); end
    @(posedge clk); #1;
    tests++; if (dut.mbr_q !== 16'h0011) begin fails++; $display("FAIL skid_replay got %h want 0011", dut.mbr_q); end
    repeat (2) @(posedge clk); #1;
    tests++; if (dut.br_q !== 16'h0000) begin fails++; $display("FAIL skid_drop got br=%h want 0000", dut.br_q); end
  endtask

  task automatic test_multi_alu();
    do_reset();
    load_mbr(16'h0002); cyc(b(MBR2ACC));
    load_mbr(16'h0003); cyc(b(MBR2BR));
    cyc(b(ALU_ADD) | b(ALU_SUB));
    tests++; if (dut.acc_q !== 16'h0005 || flags !== 8'h10) begin fails++; $display("FAIL multi_alu got acc=%h flags=%h want 0005 10", dut.acc_q, flags); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(b(MEMORY2MBR));
    cyc(b(PC_PLUS1));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tests++; if (mem_if.mem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rstmid_req got req=%b stall=%b want 0 0", mem_if.mem_req, stall); end
    ack(16'hBEEF);
    @(posedge clk); #1;
    tests++; if (dut.mbr_q !== 16'h0000 || dut.pc_q !== 8'h00 || mem_if.mem_req !== 1'b0)
      begin fails++; $display("FAIL rstmid_late got mbr=%h pc=%h req=%b want 0000 00 0", dut.mbr_q, dut.pc_q, mem_if.mem_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    load_mbr(16'h4444);
    cyc(b(MEMORY2MBR));
`ifdef DP_MEM_TIMEOUT_EN
    repeat (7) @(posedge clk); #1;
    tests++; if (mem_if.mem_req !== 1'b1) begin fails++; $display("FAIL tmo_early got req=%b want 1", mem_if.mem_req); end
    @(posedge clk); #1;
    tests++; if (mem_if.mem_req !== 1'b0 || flags[F_ERR] !== 1'b1 || dut.mbr_q !== 16'h4444)
      begin fails++; $display("FAIL tmo_abort got req=%b err=%b mbr=%h want 0 1 4444", mem_if.mem_req, flags[F_ERR], dut.mbr_q); end
`else
    repeat (100) @(posedge clk); #1;
    tests++; if (mem_if.mem_req !== 1'b1 || stall !== 1'b1) begin fails++; $display("FAIL tmo_wait got req=%b stall=%b want 1 1", mem_if.mem_req, stall); end
    do_reset();
    tests++; if (mem_if.mem_req !== 1'b0) begin fails++; $display("FAIL tmo_reset got req=%b want 0", mem_if.mem_req); end
`endif
  endtask

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    #1;
    test_reset();
    test_fetch();
    test_add_overflow();
    test_mpy();
    test_pc_wrap();
    test_clear_add();
    test_asr();
    test_write();
    test_skid();
    test_multi_alu();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
